// File: rtl/sm_cfg_loader_pkg.sv
// rtl/sm_cfg_loader_pkg.sv - shared encodings for the switch-matrix config loader
package sm_cfg_loader_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [2:0] SEL_HIZ    = 3'd0;
  localparam logic [2:0] SEL_TOP    = 3'd1;
  localparam logic [2:0] SEL_RIGHT  = 3'd2;
  localparam logic [2:0] SEL_BOTTOM = 3'd3;
  localparam logic [2:0] SEL_LEFT   = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_CSUM  = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/sm_cfg_loader_if.sv
// rtl/sm_cfg_loader_if.sv - byte stream handshake into the config loader
interface sm_cfg_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sm_cfg_loader_entry_check.sv
// rtl/sm_cfg_loader_entry_check.sv - combinational range check of one entry byte
module sm_entry_check
  import sm_cfg_loader_pkg::*;
#(
  parameter int NTB = 5,
  parameter int NLR = 4
) (
  input  logic [7:0] entry,
  output logic       entry_ok
);

  logic [2:0] sel;
  logic [2:0] idx;
  logic       bad;

  assign sel = entry[2:0];
  assign idx = entry[5:3];

  // idx only matters for sides that actually exist; hi-Z ignores it
  always_comb begin
    bad = 1'b0;
    if (entry[7:6] != 2'b00) bad = 1'b1;
    if (sel > SEL_LEFT) bad = 1'b1;
    if ((sel == SEL_TOP || sel == SEL_BOTTOM) && (32'(idx) >= NTB)) bad = 1'b1;
    if ((sel == SEL_RIGHT || sel == SEL_LEFT) && (32'(idx) >= NLR)) bad = 1'b1;
  end

  assign entry_ok = ~bad;

endmodule

// File: rtl/sm_cfg_loader.sv
// rtl/sm_cfg_loader.sv - framed byte-stream loader for switch-matrix routing config
module sm_cfg_loader
  import sm_cfg_loader_pkg::*;
#(
  parameter int         NTB  = 5,
  parameter int         NLR  = 4,
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  sm_cfg_loader_if.slave                 s,
  input  logic                           cfg_abort,
  output logic [6*(2*NTB+2*NLR)-1:0]     cfg_out,
  output logic                           busy,
  output logic                           cfg_done,
  output logic                           cfg_err,
  output logic [1:0]                     err_code
);

  localparam int NE = 2*NTB + 2*NLR;
  localparam int W  = 6*NE;
  localparam int CW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NE-1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic          rng_q, rng_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [W-1:0]  cfg_q, cfg_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic          in_frame;
  logic          ready_w;
  logic          accept;
  logic          entry_ok;

  sm_entry_check #(.NTB(NTB), .NLR(NLR)) u_check (
    .entry    (s.in_data),
    .entry_ok (entry_ok)
  );

  assign in_frame = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign ready_w  = (state_q != ST_COMMIT) && !(cfg_abort && in_frame);
  assign accept   = s.in_valid && ready_w;

  // The commit decision is taken as the checksum byte is accepted so that
  // cfg_out and the result pulse are both visible during the COMMIT cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    rng_d    = rng_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept && s.in_data == SYNC) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          csum_d  = 8'h00;
          rng_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cfg_abort) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
        end else if (accept) begin
          shadow_d[32'(cnt_q)*6 +: 6] = s.in_data[5:0];
          csum_d = csum_q ^ s.in_data;
          rng_d  = rng_q | ~entry_ok;
          if (cnt_q == LAST) begin
            state_d = ST_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_CHECK: begin
        if (cfg_abort) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
        end else if (accept) begin
          state_d = ST_COMMIT;
          if (rng_q) begin
            err_d  = 1'b1;
            code_d = ERR_RANGE;
          end else if (csum_q != s.in_data) begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end else begin
            cfg_d  = shadow_q;
            done_d = 1'b1;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      csum_q   <= 8'h00;
      rng_q    <= 1'b0;
      shadow_q <= '0;
      cfg_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      rng_q    <= rng_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign s.in_ready = ready_w;
  assign cfg_out    = cfg_q;
  assign busy       = (state_q != ST_IDLE);
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_sm_cfg_loader.sv
// tb/tb_sm_cfg_loader.sv - directed self-checking bench for sm_cfg_loader
module tb_sm_cfg_loader;

  localparam int NTB = 5;
  localparam int NLR = 4;
  localparam int NE  = 2*NTB + 2*NLR;
  localparam int W   = 6*NE;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_abort = 1'b0;
  logic [W-1:0] cfg_out;
  logic         busy, cfg_done, cfg_err;
  logic [1:0]   err_code;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   fr [NE];
  logic [W-1:0] exp_out;
  logic [W-1:0] prev_out;
  logic [7:0]   cs;

  sm_cfg_loader_if bus ();

  sm_cfg_loader #(.NTB(NTB), .NLR(NLR), .SYNC(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus),
    .cfg_abort (cfg_abort),
    .cfg_out   (cfg_out),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    #1;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) chk("ready_timeout", {127'b0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] csum, input int maxgap);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    for (int k = 0; k < NE; k++) send_byte(fr[k], $urandom_range(0, maxgap));
    send_byte(csum, $urandom_range(0, maxgap));
  endtask

  task automatic check_commit(input string tag, input logic done_e, input logic err_e,
                              input logic [1:0] code_e, input logic [W-1:0] out_e);
    @(negedge clk);
    chk({tag, "_done"}, {127'b0, cfg_done}, {127'b0, done_e});
    chk({tag, "_err"}, {127'b0, cfg_err}, {127'b0, err_e});
    if (err_e) chk({tag, "_code"}, {126'b0, err_code}, {126'b0, code_e});
    chk({tag, "_out"}, {{(128-W){1'b0}}, cfg_out}, {{(128-W){1'b0}}, out_e});
    chk({tag, "_ready_commit"}, {127'b0, bus.in_ready}, 128'd0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {126'b0, cfg_done, cfg_err}, 128'd0);
    chk({tag, "_idle"}, {127'b0, busy}, 128'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // reset state
    #1;
    chk("rst_out", {{(128-W){1'b0}}, cfg_out}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_pulses", {126'b0, cfg_done, cfg_err}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {127'b0, bus.in_ready}, 128'd1);
    chk("rst_code", {126'b0, err_code}, 128'd0);

    // valid frame, all entries idx1/top
    for (int k = 0; k < NE; k++) fr[k] = 8'h09;
    send_frame(8'h00, 0);
    check_commit("valid09", 1'b1, 1'b0, 2'b00, {NE{6'b001001}});

    // bad checksum
    send_frame(8'h01, 0);
    check_commit("csum", 1'b0, 1'b1, 2'b10, {NE{6'b001001}});

    // left0 = idx4/right is out of range with NLR=4
    fr[10] = 8'h22;
    send_frame(8'h2B, 0);
    check_commit("range", 1'b0, 1'b1, 2'b01, {NE{6'b001001}});

    // SYNC value inside LOAD is plain (range-invalid) data, alignment kept
    for (int k = 0; k < NE; k++) fr[k] = 8'h09;
    fr[3] = 8'hA5;
    send_frame(8'hAC, 0);
    check_commit("sync_in_load", 1'b0, 1'b1, 2'b01, {NE{6'b001001}});

    // abort after entry 7
    send_byte(8'hA5, 0);
    for (int k = 0; k < 7; k++) send_byte(8'h09, 0);
    @(negedge clk);
    cfg_abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h09;
    #1;
    chk("abort_ready", {127'b0, bus.in_ready}, 128'd0);
    @(negedge clk);
    cfg_abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_err", {127'b0, cfg_err}, 128'd1);
    chk("abort_code", {126'b0, err_code}, 128'd3);
    chk("abort_idle", {127'b0, busy}, 128'd0);
    chk("abort_out", {{(128-W){1'b0}}, cfg_out}, {{(128-W){1'b0}}, {NE{6'b001001}}});
    @(negedge clk);
    chk("abort_pulse_end", {127'b0, cfg_err}, 128'd0);

    // next frame after abort commits: idx3/right everywhere
    for (int k = 0; k < NE; k++) fr[k] = 8'h1A;
    send_frame(8'h00, 0);
    check_commit("after_abort", 1'b1, 1'b0, 2'b00, {NE{6'b011010}});

    // leading garbage, then a varied frame with random gaps
    send_byte(8'h00, 1);
    send_byte(8'h5A, 0);
    send_byte(8'hFF, 2);
    chk("garbage_idle", {127'b0, busy}, 128'd0);
    cs = 8'h00;
    for (int k = 0; k < NE; k++) begin
      if (k < NTB)             fr[k] = 8'((k << 3) | 1);
      else if (k < 2*NTB)      fr[k] = 8'(((k - NTB) << 3) | 3);
      else if (k < 2*NTB+NLR)  fr[k] = 8'(((k - 2*NTB) << 3) | 4);
      else                     fr[k] = 8'(((k - 2*NTB - NLR) << 3) | 2);
      cs = cs ^ fr[k];
      exp_out[6*k +: 6] = fr[k][5:0];
    end
    send_frame(cs, 3);
    check_commit("gaps", 1'b1, 1'b0, 2'b00, exp_out);

    // reset mid-frame
    prev_out = cfg_out;
    chk("pre_rst_nonzero", {127'b0, (prev_out != '0)}, 128'd1);
    send_byte(8'hA5, 0);
    for (int k = 0; k < 5; k++) send_byte(8'h09, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out", {{(128-W){1'b0}}, cfg_out}, 128'd0);
    chk("midrst_busy", {127'b0, busy}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_pulse", {126'b0, cfg_done, cfg_err}, 128'd0);
    end
    chk("midrst_ready", {127'b0, bus.in_ready}, 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_cfg_loader.md
SM_CFG_LOADER -- requirements
Module: sm_cfg_loader

Interface
REQ-001 Parameter NTB, default 5: wire count on top and bottom sides of the switch matrix.
REQ-002 Parameter NLR, default 4: wire count on left and right sides.
REQ-003 Parameter SYNC, default 8'hA5: frame start byte.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  in_data holds a byte.
REQ-007 in_data  input  8  config stream byte.
REQ-008 in_ready  output  1  loader accepts byte; transfer when in_valid and in_ready are both high.
REQ-009 cfg_abort  input  1  discard the frame in progress.
REQ-010 cfg_out  output  6*(2*NTB+2*NLR)  active routing config; entry k at bits [6k+5:6k]; entry {idx[5:3], sel[2:0]}; sel 0 = hi-Z, 1 top, 2 right, 3 bottom, 4 left.
REQ-011 busy  output  1  frame in progress (state not IDLE).
REQ-012 cfg_done  output  1  one-cycle pulse: new config committed.
REQ-013 cfg_err  output  1  one-cycle pulse: frame rejected.
REQ-014 err_code  output  2  valid with cfg_err: 01 field range, 10 checksum, 11 abort.

Function
REQ-015 Frame SHALL be: SYNC, then 2*NTB+2*NLR entry bytes (order top0..top(NTB-1), bottom0.., left0.., right0..), then one checksum byte equal to XOR of all entry bytes.
REQ-016 FSM states SHALL be IDLE, LOAD, CHECK, COMMIT.
REQ-017 IDLE: accepted byte equal to SYNC -> LOAD with entry counter cleared; other bytes SHALL be dropped silently.
REQ-018 LOAD: each accepted byte SHALL be written to shadow entry[counter], XORed into running checksum, and increment the counter; after the last entry -> CHECK.
REQ-019 Entry byte SHALL be range-invalid if bits[7:6] != 0, sel > 4, or sel in {1,3} with idx >= NTB, or sel in {2,4} with idx >= NLR; idx is ignored when sel = 0.
REQ-020 Range error SHALL set a sticky flag; loading SHALL continue to keep frame alignment.
REQ-021 CHECK: accepted byte is the checksum; -> COMMIT.
REQ-022 COMMIT (one cycle, in_ready low): if range flag set, pulse cfg_err with 01; else if checksum mismatch, pulse cfg_err with 10; else copy shadow to cfg_out and pulse cfg_done; then -> IDLE.
REQ-023 Latency: cfg_out SHALL update, and cfg_done SHALL assert, in the cycle after the checksum byte is accepted.
REQ-024 in_ready SHALL be high in IDLE, LOAD and CHECK, and low in COMMIT.
REQ-025 cfg_out SHALL change only on a successful COMMIT; a rejected or aborted frame leaves it unchanged.
REQ-026 cfg_abort in LOAD or CHECK SHALL return to IDLE next cycle and pulse cfg_err with 11; any byte presented that cycle is not accepted (in_ready low while cfg_abort high).
REQ-027 cfg_abort in IDLE or COMMIT SHALL be ignored; COMMIT completes normally.
REQ-028 A SYNC-valued byte inside LOAD SHALL be treated as data, not as a restart.
REQ-029 Stalls (in_valid low) SHALL be permitted anywhere in a frame without loss of state.

Reset
REQ-030 rst SHALL force: state IDLE, counter 0, checksum 0, range flag 0, shadow 0, cfg_out all zero (every wire hi-Z), cfg_done 0, cfg_err 0, err_code 00, busy 0.
REQ-031 rst asserted mid-frame SHALL discard the frame without a cfg_err pulse.

Structure
REQ-032 Shared package SHALL hold the sel encodings (0..4), the FSM state encoding, the error codes, and SYNC.
REQ-033 One sub-module, sm_entry_check: combinational range check of one entry byte against NTB/NLR.

Verification
REQ-034 After reset: cfg_out = 0, in_ready = 1, busy = 0.
REQ-035 Valid frame, all entries 8'h09 (idx 1, top), checksum 8'h00 (even count) -> cfg_done pulse one cycle after checksum byte, every entry of cfg_out = 6'b001001.
REQ-036 Same frame with checksum 8'h01 -> cfg_err, err_code 10, cfg_out unchanged.
REQ-037 Entry left0 = 8'h22 (idx 4, right, NLR = 4) -> cfg_err, err_code 01, cfg_out unchanged.
REQ-038 cfg_abort after entry 7 -> cfg_err, err_code 11, state IDLE; next valid frame commits normally.
REQ-039 Random in_valid gaps plus leading garbage bytes before SYNC -> same cfg_out as a gap-free frame; rst mid-frame -> cfg_out = 0, no pulses.
